// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single data-memory port between the CPU MEM stage and the debug dump engine.
// CPU has fixed priority. A starvation counter forces in a waiting DBG read.
module dmem_port_arbiter #(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [XLEN-1:0]   i_cpu_wdata,
  input  logic [XLEN/8-1:0] i_cpu_wstrb,
  output logic              o_cpu_gnt,
  output logic              o_cpu_stall,
  output logic              o_cpu_rvalid,
  output logic [XLEN-1:0]   o_cpu_rdata,
  input  logic              i_dbg_req,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  output logic              o_dbg_gnt,
  output logic              o_dbg_rvalid,
  output logic [XLEN-1:0]   o_dbg_rdata,
  output logic              o_mem_en,
  output logic [XLEN/8-1:0] o_mem_wstrb,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [XLEN-1:0]   o_mem_wdata,
  input  logic [XLEN-1:0]   i_mem_rdata
);

  localparam logic [0:0] S_NORM  = 1'b0;
  localparam logic [0:0] S_FORCE = 1'b1;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;
  localparam logic [1:0] OWN_DBG  = 2'd2;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  logic [0:0] state, state_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic [1:0] rd_owner, rd_owner_nxt;
  logic       gnt_cpu, gnt_dbg, contend;

  // Grants are gated by reset so every output reads 0 while reset is held.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    gnt_cpu = 1'b0;
    gnt_dbg = 1'b0;
    if (i_rst_n) begin
      if (state == S_FORCE) begin
        gnt_dbg = i_dbg_req;
      end else begin
        gnt_cpu = i_cpu_req;
        gnt_dbg = ~i_cpu_req & i_dbg_req;
      end
    end
  end

  assign contend = (state == S_NORM) & i_cpu_req & i_dbg_req;

  always_comb begin
    state_nxt    = S_NORM;
    wait_cnt_nxt = wait_cnt;
    if (contend && wait_cnt == WAIT_LAST) state_nxt = S_FORCE;

    if (gnt_dbg || !i_dbg_req) begin
      wait_cnt_nxt = 8'd0;
    end else if (contend) begin
      if (wait_cnt == WAIT_LAST)  wait_cnt_nxt = 8'd0;
      else if (wait_cnt != 8'hFF) wait_cnt_nxt = wait_cnt + 8'd1;
    end

    rd_owner_nxt = OWN_NONE;
    if (gnt_cpu && !i_cpu_we) rd_owner_nxt = OWN_CPU;
    else if (gnt_dbg)         rd_owner_nxt = OWN_DBG;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= S_NORM;
      wait_cnt <= 8'd0;
      rd_owner <= OWN_NONE;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      rd_owner <= rd_owner_nxt;
    end
  end

  assign o_cpu_gnt   = gnt_cpu;
  assign o_dbg_gnt   = gnt_dbg;
  assign o_cpu_stall = i_rst_n & i_cpu_req & ~gnt_cpu;

  assign o_mem_en    = gnt_cpu | gnt_dbg;
  assign o_mem_wstrb = (gnt_cpu & i_cpu_we) ? i_cpu_wstrb : '0;
  assign o_mem_addr  = gnt_cpu ? i_cpu_addr : (gnt_dbg ? i_dbg_addr : '0);
  assign o_mem_wdata = gnt_cpu ? i_cpu_wdata : '0;

  // Read data lands one cycle after issue; only the owning port sees it.
  assign o_cpu_rvalid = (rd_owner == OWN_CPU);
  assign o_dbg_rvalid = (rd_owner == OWN_DBG);
  assign o_cpu_rdata  = o_cpu_rvalid ? i_mem_rdata : '0;
  assign o_dbg_rdata  = o_dbg_rvalid ? i_mem_rdata : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter (MAX_WAIT=4) with a synchronous memory model
// and per-port read-data scoreboard queues.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0]  cpu_wstrb;
  logic        dbg_req, dbg_gnt, dbg_rvalid;
  logic [31:0] dbg_addr, dbg_rdata;
  logic        mem_en;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  logic [31:0] mem     [0:255];
  logic [31:0] exp_mem [0:255];
  logic [31:0] cpu_q[$];
  logic [31:0] dbg_q[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.XLEN(32), .ADDR_W(32), .MAX_WAIT(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr),
    .i_cpu_wdata(cpu_wdata), .i_cpu_wstrb(cpu_wstrb),
    .o_cpu_gnt(cpu_gnt), .o_cpu_stall(cpu_stall),
    .o_cpu_rvalid(cpu_rvalid), .o_cpu_rdata(cpu_rdata),
    .i_dbg_req(dbg_req), .i_dbg_addr(dbg_addr),
    .o_dbg_gnt(dbg_gnt), .o_dbg_rvalid(dbg_rvalid), .o_dbg_rdata(dbg_rdata),
    .o_mem_en(mem_en), .o_mem_wstrb(mem_wstrb), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  // Synchronous single-port memory, read data one cycle after issue.
  always @(posedge clk) begin
    if (mem_en) begin
      if (|mem_wstrb) begin
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_addr[9:2]];
      end
    end
  end

  // One clock cycle: drive, sample at negedge, score, advance to just past the next posedge.
  task automatic cycle(input string name, input logic c_req, input logic c_we,
                       input logic [31:0] c_addr, input logic [31:0] c_wdata,
                       input logic [3:0] c_wstrb, input logic d_req, input logic [31:0] d_addr,
                       input logic e_cg, input logic e_dg);
    logic [31:0] exp_d;
    logic [3:0]  exp_ws;
    cpu_req = c_req; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wdata;
    cpu_wstrb = c_wstrb; dbg_req = d_req; dbg_addr = d_addr;
    @(negedge clk);
    checks++;
    if (cpu_gnt !== e_cg) begin
      errors++; $display("FAIL %s cpu_gnt got %b exp %b", name, cpu_gnt, e_cg);
    end
    checks++;
    if (dbg_gnt !== e_dg) begin
      errors++; $display("FAIL %s dbg_gnt got %b exp %b", name, dbg_gnt, e_dg);
    end
    checks++;
    if (cpu_stall !== (c_req & ~e_cg)) begin
      errors++; $display("FAIL %s cpu_stall got %b exp %b", name, cpu_stall, c_req & ~e_cg);
    end
    checks++;
    if (mem_en !== (e_cg | e_dg)) begin
      errors++; $display("FAIL %s mem_en got %b exp %b", name, mem_en, e_cg | e_dg);
    end
    exp_ws = (e_cg && c_we) ? c_wstrb : 4'h0;
    checks++;
    if (mem_wstrb !== exp_ws) begin
      errors++; $display("FAIL %s mem_wstrb got %h exp %h", name, mem_wstrb, exp_ws);
    end
    if (e_cg || e_dg) begin
      checks++;
      if (mem_addr !== (e_cg ? c_addr : d_addr)) begin
        errors++; $display("FAIL %s mem_addr got %h exp %h", name, mem_addr, e_cg ? c_addr : d_addr);
      end
    end
    if (e_cg && c_we) begin
      checks++;
      if (mem_wdata !== c_wdata) begin
        errors++; $display("FAIL %s mem_wdata got %h exp %h", name, mem_wdata, c_wdata);
      end
    end
    // Scoreboard: a non-empty queue means a read from last cycle must return now.
    checks++;
    if (cpu_rvalid !== (cpu_q.size() != 0)) begin
      errors++; $display("FAIL %s cpu_rvalid got %b exp %b", name, cpu_rvalid, cpu_q.size() != 0);
    end
    exp_d = (cpu_q.size() != 0) ? cpu_q.pop_front() : 32'h0;
    checks++;
    if (cpu_rdata !== exp_d) begin
      errors++; $display("FAIL %s cpu_rdata got %h exp %h", name, cpu_rdata, exp_d);
    end
    checks++;
    if (dbg_rvalid !== (dbg_q.size() != 0)) begin
      errors++; $display("FAIL %s dbg_rvalid got %b exp %b", name, dbg_rvalid, dbg_q.size() != 0);
    end
    exp_d = (dbg_q.size() != 0) ? dbg_q.pop_front() : 32'h0;
    checks++;
    if (dbg_rdata !== exp_d) begin
      errors++; $display("FAIL %s dbg_rdata got %h exp %h", name, dbg_rdata, exp_d);
    end
    if (e_cg && !c_we) cpu_q.push_back(exp_mem[c_addr[9:2]]);
    if (e_cg && c_we)
      for (int b = 0; b < 4; b++)
        if (c_wstrb[b]) exp_mem[c_addr[9:2]][8*b +: 8] = c_wdata[8*b +: 8];
    if (e_dg) dbg_q.push_back(exp_mem[d_addr[9:2]]);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    cycle("idle", 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  // Continuous contention with CPU loads: MAX_WAIT=4 CPU grants, then one forced DBG grant.
  task automatic contend_round(input string name, input int base);
    for (int i = 0; i < 4; i++)
      cycle(name, 1'b1, 1'b0, 32'(base + 4*i), 32'h0, 4'h0, 1'b1, 32'h200, 1'b1, 1'b0);
    cycle(name, 1'b1, 1'b0, 32'(base + 16), 32'h0, 4'h0, 1'b1, 32'h200, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100; cpu_wdata = 32'h0;
    cpu_wstrb = 4'h0; dbg_req = 1'b1; dbg_addr = 32'h100;
    #3;
    checks++;
    if ({cpu_gnt, dbg_gnt, cpu_stall, mem_en, cpu_rvalid, dbg_rvalid} !== 6'b0) begin
      errors++;
      $display("FAIL reset outputs got %b exp 000000",
               {cpu_gnt, dbg_gnt, cpu_stall, mem_en, cpu_rvalid, dbg_rvalid});
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_cpu_store_load();
    cycle("store", 1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, 1'b1, 1'b0);
    cycle("load", 1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    cycle("pstore", 1'b1, 1'b1, 32'h104, 32'h11223344, 4'h3, 1'b0, 32'h0, 1'b1, 1'b0);
    cycle("pload", 1'b1, 1'b0, 32'h104, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    idle();
  endtask

  task automatic test_starvation();
    contend_round("starve1", 32'h10);
    contend_round("starve2", 32'h40);
    idle();
  endtask

  task automatic test_wait_clear();
    // Partial contention, then DBG drops: the counter must restart from zero.
    cycle("wclr", 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1, 32'h200, 1'b1, 1'b0);
    cycle("wclr", 1'b1, 1'b0, 32'h24, 32'h0, 4'h0, 1'b1, 32'h200, 1'b1, 1'b0);
    cycle("wclr", 1'b1, 1'b0, 32'h28, 32'h0, 4'h0, 1'b0, 32'h200, 1'b1, 1'b0);
    contend_round("wclr_round", 32'h30);
    idle();
  endtask

  task automatic test_dbg_only();
    cycle("dbg_only", 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h100, 1'b0, 1'b1);
    idle();
    contend_round("dbg_cnt0", 32'h60);
    idle();
  endtask

  task automatic test_back_to_back();
    cycle("b2b_cpu", 1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    cycle("b2b_dbg", 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h104, 1'b0, 1'b1);
    cycle("b2b_cpu2", 1'b1, 1'b0, 32'h108, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    idle();
  endtask

  task automatic test_reset_mid();
    for (int pre = 3; pre <= 4; pre++) begin
      for (int i = 0; i < pre; i++)
        cycle("mid_pre", 1'b1, 1'b0, 32'(32'h80 + 4*i), 32'h0, 4'h0, 1'b1, 32'h200, 1'b1, 1'b0);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({cpu_rvalid, dbg_rvalid, cpu_gnt, dbg_gnt, cpu_stall} !== 5'b0) begin
        errors++;
        $display("FAIL mid_reset outputs got %b exp 00000",
                 {cpu_rvalid, dbg_rvalid, cpu_gnt, dbg_gnt, cpu_stall});
      end
      cpu_q.delete(); dbg_q.delete();
      cpu_req = 1'b0; dbg_req = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      contend_round("post_reset", 32'hA0);
      idle();
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'h5A000000 | 32'(i * 257);
      exp_mem[i] = 32'h5A000000 | 32'(i * 257);
    end
    test_reset();
    test_cpu_store_load();
    test_starvation();
    test_wait_clear();
    test_dbg_only();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
